// File: rtl/parking_gate_ctrl.sv
// Parking-lot gate sequencer: entry password check, timed gate opening,
// wrong-password lockout and occupancy tracking, all timed by a prescaled tick.
module parking_gate_ctrl #(
    parameter int         TICK_DIV   = 1000,
    parameter logic [7:0] PASSWORD   = 8'hA5,
    parameter int         PASS_TICKS = 10,
    parameter int         OPEN_TICKS = 5,
    parameter int         LOCK_TICKS = 20,
    parameter int         MAX_TRIES  = 3,
    parameter int         CAPACITY   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_entry,
    input  logic       sensor_exit,
    input  logic       pass_valid,
    input  logic [7:0] pass_data,
    output logic       gate_open,
    output logic       green_led,
    output logic       red_led,
    output logic       alarm,
    output logic [1:0] state,
    output logic [3:0] spaces_free,
    output logic       full
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_PASS = 2'd1,
        GATE_OPEN = 2'd2,
        ALARM     = 2'd3
    } state_t;

    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAXT = (PASS_TICKS > OPEN_TICKS)
                        ? ((PASS_TICKS > LOCK_TICKS) ? PASS_TICKS : LOCK_TICKS)
                        : ((OPEN_TICKS > LOCK_TICKS) ? OPEN_TICKS : LOCK_TICKS);
    localparam int EW   = $clog2(MAXT + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_ONE   = PW'(1);
    localparam logic [EW-1:0] ELA_ONE   = EW'(1);
    localparam logic [EW-1:0] PASS_LAST = EW'(PASS_TICKS - 1);
    localparam logic [EW-1:0] OPEN_LAST = EW'(OPEN_TICKS - 1);
    localparam logic [EW-1:0] LOCK_LAST = EW'(LOCK_TICKS - 1);
    localparam logic [3:0]    CAP       = 4'(CAPACITY);
    localparam logic [2:0]    TRIES_MAX = 3'(MAX_TRIES);

    state_t        st, st_nxt;
    logic [PW-1:0] prescaler;
    logic [EW-1:0] elapsed;
    logic [2:0]    tries, tries_nxt;
    logic [3:0]    occupied, occ_nxt;
    logic          dir, dir_nxt;   // 0 = car entering, 1 = car leaving
    logic          tick;
    logic          is_full;

    assign tick    = (prescaler == PRE_LAST);
    assign is_full = (occupied == CAP);
    assign state   = st;

    // pass_valid is a one-cycle strobe with no ready/backpressure: it qualifies
    // pass_data on that cycle only and is consumed solely in WAIT_PASS.
    always_comb begin
        st_nxt    = st;
        tries_nxt = tries;
        occ_nxt   = occupied;
        dir_nxt   = dir;
        case (st)
            IDLE: begin
                if (sensor_exit && (occupied != 4'd0)) begin
                    st_nxt  = GATE_OPEN;
                    dir_nxt = 1'b1;
                end else if (sensor_entry && !is_full) begin
                    st_nxt    = WAIT_PASS;
                    tries_nxt = 3'd0;
                end
            end
            WAIT_PASS: begin
                if (pass_valid) begin
                    if (pass_data == PASSWORD) begin
                        st_nxt  = GATE_OPEN;
                        dir_nxt = 1'b0;
                    end else begin
                        tries_nxt = tries + 3'd1;
                        if (tries_nxt == TRIES_MAX)
                            st_nxt = ALARM;
                    end
                end else if (tick && (elapsed == PASS_LAST)) begin
                    st_nxt = IDLE;
                end
            end
            GATE_OPEN: begin
                if (tick && (elapsed == OPEN_LAST)) begin
                    st_nxt = IDLE;
                    if (dir)
                        occ_nxt = (occupied == 4'd0) ? 4'd0 : occupied - 4'd1;
                    else
                        occ_nxt = (occupied == CAP) ? CAP : occupied + 4'd1;
                end
            end
            ALARM: begin
                if (tick && (elapsed == LOCK_LAST)) begin
                    st_nxt    = IDLE;
                    tries_nxt = 3'd0;
                end
            end
            default: st_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next-state values so they switch on the
    // same edge as the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st          <= IDLE;
            prescaler   <= '0;
            elapsed     <= '0;
            tries       <= 3'd0;
            occupied    <= 4'd0;
            dir         <= 1'b0;
            gate_open   <= 1'b0;
            green_led   <= 1'b0;
            red_led     <= 1'b0;
            alarm       <= 1'b0;
            spaces_free <= CAP;
            full        <= 1'b0;
        end else begin
            st       <= st_nxt;
            tries    <= tries_nxt;
            occupied <= occ_nxt;
            dir      <= dir_nxt;
            if (st_nxt != st) begin
                prescaler <= '0;
                elapsed   <= '0;
            end else if (tick) begin
                prescaler <= '0;
                elapsed   <= elapsed + ELA_ONE;
            end else begin
                prescaler <= prescaler + PRE_ONE;
            end
            gate_open   <= (st_nxt == GATE_OPEN);
            green_led   <= (st_nxt == GATE_OPEN);
            alarm       <= (st_nxt == ALARM);
            red_led     <= (st_nxt == WAIT_PASS) || (st_nxt == ALARM) ||
                           ((st_nxt == IDLE) && (occ_nxt == CAP));
            spaces_free <= CAP - occ_nxt;
            full        <= (occ_nxt == CAP);
        end
    end

endmodule
